// File: rtl/branch_target_buffer.sv
// Tagged branch target buffer: zero-latency fetch lookup, execute-stage allocate/update,
// and a one-entry-per-cycle invalidate sweep started by flush_i.
`ifndef NON_BRANCH
`define NON_BRANCH 2'b00
`endif

module branch_target_buffer #(
   parameter int XLEN      = 32,
   parameter int IDX_BITS  = 10,
   parameter int TAG_BITS  = 8,
   parameter int HIST_BITS = 2
) (
   input  logic                 clk_i,
   input  logic                 reset_n_i,
   input  logic [XLEN-1:0]      pc_fi_i,
   input  logic [HIST_BITS-1:0] local_src_fi_i,
   input  logic [XLEN-1:0]      pc_ex_i,
   input  logic [HIST_BITS-1:0] local_src_ex_i,
   input  logic [XLEN-1:0]      pc_target_ex_i,
   input  logic [1:0]           branch_op_ex_i,
   input  logic                 pc_src_res_ex_i,
   input  logic                 target_match_i,
   input  logic                 flush_i,
   output logic                 pc_src_pred_fi_o,
   output logic [XLEN-1:0]      pred_pc_target_fi_o,
   output logic                 btb_hit_fi_o,
   output logic                 busy_o
);

   localparam int ENTRIES = 2 ** IDX_BITS;
   localparam int CTRS    = 2 ** HIST_BITS;
   localparam int TW      = (TAG_BITS > 0) ? TAG_BITS : 1;

   typedef enum logic {IDLE, SWEEP} state_e;

   state_e               state_q, state_d;
   logic [IDX_BITS-1:0]  sweep_ptr_q, sweep_ptr_d;

   logic                 valid_q  [ENTRIES];
   logic [TW-1:0]        tag_q    [ENTRIES];
   logic [XLEN-1:0]      target_q [ENTRIES];
   logic [1:0]           ctr_q    [ENTRIES][CTRS];

   logic [IDX_BITS-1:0]  idx_fi, idx_ex;
   logic [TW-1:0]        tag_fi, tag_ex;
   logic                 hit_fi, ex_hit, upd_en, alloc;
   logic [1:0]           ctr_ex;
   logic                 unused_pc_bits;

   assign idx_fi = pc_fi_i[IDX_BITS+1:2];
   assign idx_ex = pc_ex_i[IDX_BITS+1:2];

   // An untagged buffer stores and compares a constant zero, so every valid entry matches.
   generate
      if (TAG_BITS > 0) begin : g_tag
         assign tag_fi = pc_fi_i[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
         assign tag_ex = pc_ex_i[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
      end else begin : g_notag
         assign tag_fi = '0;
         assign tag_ex = '0;
      end
   endgenerate

   assign unused_pc_bits = ^{pc_fi_i, pc_ex_i};

   assign busy_o              = (state_q == SWEEP);
   assign hit_fi              = valid_q[idx_fi] && (tag_q[idx_fi] == tag_fi) && !busy_o;
   assign btb_hit_fi_o        = hit_fi;
   assign pc_src_pred_fi_o    = hit_fi && ctr_q[idx_fi][local_src_fi_i][1];
   assign pred_pc_target_fi_o = hit_fi ? target_q[idx_fi] : '0;

   assign upd_en = (branch_op_ex_i != `NON_BRANCH) && (state_q == IDLE);
   assign ex_hit = valid_q[idx_ex] && (tag_q[idx_ex] == tag_ex);
   assign alloc  = !ex_hit || !target_match_i;
   assign ctr_ex = ctr_q[idx_ex][local_src_ex_i];

   always_comb begin
      state_d     = state_q;
      sweep_ptr_d = sweep_ptr_q;
      case (state_q)
         IDLE: begin
            sweep_ptr_d = '0;
            if (flush_i) state_d = SWEEP;
         end
         SWEEP: begin
            sweep_ptr_d = sweep_ptr_q + 1'b1;
            if (&sweep_ptr_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q     <= IDLE;
         sweep_ptr_q <= '0;
         for (int e = 0; e < ENTRIES; e++) begin
            valid_q[e] <= 1'b0;
            for (int c = 0; c < CTRS; c++) ctr_q[e][c] <= 2'b01;
         end
      end else begin
         state_q     <= state_d;
         sweep_ptr_q <= sweep_ptr_d;
         if (state_q == SWEEP) begin
            valid_q[sweep_ptr_q] <= 1'b0;
         end else if (upd_en) begin
            valid_q[idx_ex] <= 1'b1;
            if (alloc) begin
               for (int c = 0; c < CTRS; c++) begin
                  if (c == int'(local_src_ex_i))
                     ctr_q[idx_ex][c] <= pc_src_res_ex_i ? 2'b10 : 2'b01;
                  else
                     ctr_q[idx_ex][c] <= 2'b01;
               end
            end else if (pc_src_res_ex_i) begin
               if (ctr_ex != 2'b11) ctr_q[idx_ex][local_src_ex_i] <= ctr_ex + 2'd1;
            end else begin
               if (ctr_ex != 2'b00) ctr_q[idx_ex][local_src_ex_i] <= ctr_ex - 2'd1;
            end
         end
      end
   end

   // Tags and targets are masked by the valid bits, so they carry no reset.
   always_ff @(posedge clk_i) begin
      if (upd_en && alloc) begin
         tag_q[idx_ex]    <= tag_ex;
         target_q[idx_ex] <= pc_target_ex_i;
      end
   end

endmodule
